// File: rtl/scene_pkg.sv
// Shared types and constants for the scene compositor: FSM states, fade level range
// and the status codes published to the sprite modules.
package scene_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FADE_OUT,
    SWAP,
    FADE_IN
  } state_e;

  localparam int LEVEL_W = 5;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 5'd16;

  typedef logic [LEVEL_W-1:0] level_t;

  localparam logic [3:0] TITLE  = 4'd0;
  localparam logic [3:0] ROOM   = 4'd3;
  localparam logic [3:0] BATTLE = 4'd4;

endpackage

// File: rtl/fade_scaler.sv
// Combinational brightness scaler: each 8-bit channel becomes (c * level) >> 4,
// so level 16 passes the colour through untouched and level 0 yields black.
module fade_scaler
  import scene_pkg::*;
(
  input  logic [23:0] color_i,
  input  level_t      level_i,
  output logic [23:0] color_o
);

  // The 13-bit product never exceeds 255*16 = 4080, so bits [11:4] hold the result.
  function automatic logic [7:0] scale_ch(input logic [7:0] c, input level_t l);
    logic [12:0] prod;
    prod = {5'b0, c} * {8'b0, l};
    return 8'(prod >> 4);
  endfunction

  assign color_o = {scale_ch(color_i[23:16], level_i),
                    scale_ch(color_i[15:8],  level_i),
                    scale_ch(color_i[7:0],   level_i)};

endmodule

// File: rtl/scene_compositor.sv
// Priority layer merge, frame-paced fade-to-black scene transition and registered RGB out.
// Build option: define SCENE_COLOR_KEY_EN to treat 24'h000000 layer colours as transparent.
module scene_compositor
  import scene_pkg::*;
#(
  parameter int          FADE_STEP = 2,
  parameter logic [23:0] BG_COLOR  = 24'h000000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        blank,
  input  logic [3:0]  status_req,
  input  logic        is_heart,
  input  logic        is_text,
  input  logic        is_door,
  input  logic        is_bg,
  input  logic [23:0] heart_color,
  input  logic [23:0] text_color,
  input  logic [23:0] door_color,
  input  logic [23:0] bg_color,
  output logic [3:0]  status,
  output logic        fading,
  output logic [7:0]  Red,
  output logic [7:0]  Green,
  output logic [7:0]  Blue
);

  localparam level_t STEP = level_t'(FADE_STEP);

  logic        frame_q, frame_tick_q;
  state_e      state_q, state_d;
  level_t      level_q, level_d;
  logic [3:0]  status_q, status_d;
  logic [3:0]  tgt_q, tgt_d;
  logic [23:0] rgb_q, merged, scaled;
  logic        heart_hit, text_hit, door_hit, bg_hit;
  logic [LEVEL_W:0] level_up;
  level_t      level_inc, level_dec;

  // NOTE: sequential state is written with <= so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_q      <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      frame_q      <= frame_clk;
      frame_tick_q <= frame_clk & ~frame_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      level_q  <= LEVEL_MAX;
      status_q <= TITLE;
      tgt_q    <= TITLE;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      status_q <= status_d;
      tgt_q    <= tgt_d;
    end
  end

  // Saturating level arithmetic; the up path is one bit wider so it cannot wrap.
  assign level_up  = {1'b0, level_q} + {1'b0, STEP};
  assign level_inc = (level_up > {1'b0, LEVEL_MAX}) ? LEVEL_MAX : level_up[LEVEL_W-1:0];
  assign level_dec = (level_q > STEP) ? level_q - STEP : '0;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    status_d = status_q;
    tgt_d    = tgt_q;
    unique case (state_q)
      IDLE: begin
        if (status_req != status_q) begin
          tgt_d   = status_req;
          state_d = FADE_OUT;
        end
      end
      FADE_OUT: begin
        tgt_d = status_req;
        if (frame_tick_q) level_d = level_dec;
        if (level_d == '0) state_d = SWAP;
      end
      SWAP: begin
        status_d = tgt_q;
        state_d  = FADE_IN;
      end
      FADE_IN: begin
        if (status_req != status_q) begin
          tgt_d   = status_req;
          state_d = FADE_OUT;
        end else if (frame_tick_q) begin
          level_d = level_inc;
          if (level_inc == LEVEL_MAX) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fading = (state_q != IDLE);
  end

`ifdef SCENE_COLOR_KEY_EN
  assign heart_hit = is_heart && (heart_color != 24'h000000);
  assign text_hit  = is_text  && (text_color  != 24'h000000);
  assign door_hit  = is_door  && (door_color  != 24'h000000);
  assign bg_hit    = is_bg    && (bg_color    != 24'h000000);
`else
  assign heart_hit = is_heart;
  assign text_hit  = is_text;
  assign door_hit  = is_door;
  assign bg_hit    = is_bg;
`endif

  always_comb begin
    merged = BG_COLOR;
    if (!blank)         merged = 24'h000000;
    else if (heart_hit) merged = heart_color;
    else if (text_hit)  merged = text_color;
    else if (door_hit)  merged = door_color;
    else if (bg_hit)    merged = bg_color;
  end

  fade_scaler u_scaler (
    .color_i (merged),
    .level_i (level_q),
    .color_o (scaled)
  );

  always_ff @(posedge Clk) begin
    if (Reset) rgb_q <= 24'h000000;
    else       rgb_q <= scaled;
  end

  assign status = status_q;
  assign Red    = rgb_q[23:16];
  assign Green  = rgb_q[15:8];
  assign Blue   = rgb_q[7:0];

endmodule

// File: tb/tb_scene_compositor.sv
// Directed bench for scene_compositor: layer priority, blanking, scaling and the
// fade/swap sequence, with expected pixels queued on drive and compared on output.
module tb_scene_compositor;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic        blank = 1'b1;
  logic [3:0]  status_req = 4'd0;
  logic        is_heart = 1'b0, is_text = 1'b0, is_door = 1'b0, is_bg = 1'b0;
  logic [23:0] heart_color = '0, text_color = '0, door_color = '0, bg_color = '0;
  logic [3:0]  status;
  logic        fading;
  logic [7:0]  Red, Green, Blue;

  int total = 0;
  int bad = 0;
  int lvl = 16;
  logic [23:0] exp_q[$];

  always #5 Clk = ~Clk;

  scene_compositor dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .blank       (blank),
    .status_req  (status_req),
    .is_heart    (is_heart),
    .is_text     (is_text),
    .is_door     (is_door),
    .is_bg       (is_bg),
    .heart_color (heart_color),
    .text_color  (text_color),
    .door_color  (door_color),
    .bg_color    (bg_color),
    .status      (status),
    .fading      (fading),
    .Red         (Red),
    .Green       (Green),
    .Blue        (Blue)
  );

  function automatic logic [23:0] model_scale(input logic [23:0] c, input int l);
    int r, g, b;
    r = (int'(c[23:16]) * l) / 16;
    g = (int'(c[15:8])  * l) / 16;
    b = (int'(c[7:0])   * l) / 16;
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Queue the expected pixel as the inputs are driven, then compare when it appears.
  task automatic send_pix(input string tag, input logic [23:0] exp);
    logic [23:0] want;
    exp_q.push_back(exp);
    step();
    want = exp_q.pop_front();
    check(tag, {8'h00, Red, Green, Blue}, {8'h00, want});
  endtask

  task automatic frame_rise();
    frame_clk = 1'b1;
    step();
    step();
  endtask

  task automatic frame_fall();
    frame_clk = 1'b0;
    step();
    step();
  endtask

  task automatic pulse_down();
    frame_rise();
    frame_fall();
    lvl = (lvl > 2) ? lvl - 2 : 0;
  endtask

  task automatic pulse_up();
    frame_rise();
    frame_fall();
    lvl = (lvl + 2 > 16) ? 16 : lvl + 2;
  endtask

  initial begin
    step();
    step();
    check("reset_rgb", {8'h00, Red, Green, Blue}, 32'h0);
    check("reset_status", {28'h0, status}, 32'h0);
    check("reset_fading", {31'h0, fading}, 32'h0);

    Reset = 1'b0;
    is_door = 1'b1;
    door_color = 24'h3a3948;
    send_pix("door_only", 24'h3a3948);

    is_heart = 1'b1;
    heart_color = 24'hFF0000;
    send_pix("heart_over_door", 24'hFF0000);

    blank = 1'b0;
    send_pix("blanked", 24'h000000);
    blank = 1'b1;

    is_heart = 1'b0;
    is_text = 1'b1;
    text_color = 24'h00A5C3;
    send_pix("text_over_door", 24'h00A5C3);

    is_text = 1'b0;
    is_door = 1'b0;
    send_pix("no_layer_bg_const", 24'h000000);

    is_bg = 1'b1;
    bg_color = 24'h123456;
    send_pix("bg_layer", 24'h123456);

    is_door = 1'b1;
    door_color = 24'h000000;
`ifdef SCENE_COLOR_KEY_EN
    send_pix("black_door_keyed", 24'h123456);
`else
    send_pix("black_door_opaque", 24'h000000);
`endif

    // Scene change 0 -> 3
    is_bg = 1'b0;
    door_color = 24'hF0F0F0;
    status_req = 4'd3;
    step();
    check("fade_start_fading", {31'h0, fading}, 32'h1);
    check("fade_start_status", {28'h0, status}, 32'h0);
    send_pix("fade_start_level16", model_scale(door_color, lvl));

    for (int i = 0; i < 7; i++) pulse_down();
    send_pix("fade_out_level2", model_scale(door_color, lvl));
    frame_rise();
    lvl = 0;
    check("swap_pending_status", {28'h0, status}, 32'h0);
    step();
    check("swap_status", {28'h0, status}, 32'h3);
    frame_fall();
    send_pix("fade_black", 24'h000000);

    for (int i = 0; i < 4; i++) pulse_up();
    door_color = 24'h3a3948;
    send_pix("fade_in_level8", 24'h1d1c24);
    door_color = 24'hF0F0F0;
    for (int i = 0; i < 4; i++) pulse_up();
    check("fade_done_fading", {31'h0, fading}, 32'h0);
    send_pix("fade_done_level16", 24'hF0F0F0);

    // Retarget during fade-out
    status_req = 4'd0;
    step();
    for (int i = 0; i < 3; i++) pulse_down();
    send_pix("fade_out_level10", model_scale(door_color, lvl));
    status_req = 4'd4;
    for (int i = 0; i < 5; i++) pulse_down();
    check("retarget_status", {28'h0, status}, 32'h4);
    for (int i = 0; i < 8; i++) pulse_up();
    check("retarget_done_fading", {31'h0, fading}, 32'h0);

    // Reversal during fade-in
    status_req = 4'd3;
    step();
    for (int i = 0; i < 8; i++) pulse_down();
    check("second_swap_status", {28'h0, status}, 32'h3);
    for (int i = 0; i < 3; i++) pulse_up();
    send_pix("fade_in_level6", model_scale(door_color, lvl));
    status_req = 4'd0;
    step();
    check("reverse_fading", {31'h0, fading}, 32'h1);
    pulse_down();
    send_pix("reverse_level4", 24'h3c3c3c);

    // Reset mid-fade, then a request matching the current status
    Reset = 1'b1;
    step();
    lvl = 16;
    check("midfade_reset_status", {28'h0, status}, 32'h0);
    check("midfade_reset_fading", {31'h0, fading}, 32'h0);
    check("midfade_reset_rgb", {8'h00, Red, Green, Blue}, 32'h0);
    Reset = 1'b0;
    status_req = 4'd0;
    step();
    check("same_req_no_fade", {31'h0, fading}, 32'h0);
    send_pix("same_req_level16", model_scale(door_color, lvl));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scene_compositor.md
Name: scene_compositor

Overview:
- Pixel-path stage directly downstream of the sprite generators (door, heart, text box) and their ROMs.
- Per pixel, it merges layer hit flags and 24-bit ROM colours into one RGB value by fixed priority, with one registered cycle of latency.
- It owns the scene-transition fade. When the game FSM requests a new status, it fades to black, switches the status it publishes to the sprite modules, then fades back in.
- Its RGB outputs drive the VGA output registers.

Parameters:
- FADE_STEP, 2, brightness change per frame_clk rising edge; legal values 1, 2, 4, 8, 16.
- BG_COLOR, 24'h000000, colour used when no layer hits.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  synchronous, active-high.
- frame_clk  in  1  VGA vsync-derived frame tick; only its rising edge is used, detected internally on Clk.
- blank  in  1  active-low blanking from the VGA controller.
- status_req  in  4  scene requested by the game FSM.
- is_heart, is_text, is_door, is_bg  in  1 each  layer hit flags for the current pixel.
- heart_color, text_color, door_color, bg_color  in  24 each  ROM colours for the corresponding layer.
- status  out  4  scene currently shown; feeds the status inputs of the sprite modules.
- fading  out  1  high while not in IDLE.
- Red, Green, Blue  out  8 each  final pixel colour.

Behaviour:
- Reset: status=0, level=16, state=IDLE, fading=0, Red/Green/Blue=0, status_tgt=0, edge detector cleared.
- Frame edge: frame_tick is one Clk wide, registered from frame_clk rising. All FSM and level changes happen only on frame_tick.
- Priority: heart > text > door > bg > BG_COLOR. A layer wins if its flag is 1. Lower-priority flags are ignored once a layer wins.
- Blank: when blank=0, the merged colour is 24'h000000 regardless of any layer.
- Scaling: each channel is computed as (c*level)>>4, with level 5-bit unsigned in the range 0..16.
  - The product is 13 bits; the result takes bits [11:4].
  - level=16 reproduces the input exactly; level=0 gives 0.
- Latency: Red/Green/Blue are registered every Clk. The output at cycle n+1 reflects the inputs and level present at cycle n.
- FSM states: IDLE, FADE_OUT, SWAP, FADE_IN.
  - IDLE: if status_req != status, latch status_tgt=status_req and go to FADE_OUT. The check happens every Clk; the level does not move until a frame_tick.
  - FADE_OUT: on each frame_tick, level = max(level-FADE_STEP, 0). When level reaches 0, go to SWAP.
  - FADE_OUT, status_req changes: status_tgt updates to the newest value and the fade continues.
  - SWAP: lasts exactly one Clk. status=status_tgt; go to FADE_IN.
  - FADE_IN: on each frame_tick, level = min(level+FADE_STEP, 16). When level reaches 16, go to IDLE.
  - FADE_IN, status_req != status: latch status_tgt and go to FADE_OUT from the current level, without a jump.
  - FADE_IN, status_req returns to status: no effect.
- fading = (state != IDLE).
- Clamp: level never leaves 0..16 for any FADE_STEP value.
- Reset mid-fade: a reset during any state returns immediately to the reset values on the next Clk.
- Same request: a request equal to the current status while in IDLE causes no fade.

Optional Feature:
- Macro: SCENE_COLOR_KEY_EN.
- Defined: a layer colour equal to 24'h000000 counts as transparent even when its flag is 1. Priority falls through to the next layer, so door ROM index 0 shows the background.
- Undefined: the flag alone decides, and black pixels are opaque.

Decomposition:
- Package scene_pkg holds:
  - the state typedef (enum of IDLE, FADE_OUT, SWAP, FADE_IN);
  - LEVEL_MAX=16 and LEVEL_W=5;
  - the status codes: TITLE=0, ROOM=3, BATTLE=4.
- One sub-module, fade_scaler: a combinational 24-bit colour by 5-bit level scaler, instantiated once on the merged colour ahead of the output register.

Test Plan:
- Reset, blank=1, is_door=1, door_color=24'h3a3948, other flags 0 -> next Clk Red=3a, Green=39, Blue=48.
- Reset, is_heart=1 with heart_color=FF0000 and is_door=1 with door_color=3a3948 -> Red=FF, Green=00, Blue=00 (heart wins). With blank=0 -> all outputs 0.
- FADE_STEP=2, status_req 0->3:
  - fading=1 immediately; level=0 after 8 frame_ticks;
  - status=3 one Clk after that;
  - level=16 and fading=0 after 8 more frame_ticks.
  - At level 8 in FADE_IN, door_color 3a3948 outputs 1d,1c,24.
- During FADE_OUT at level 10, status_req 3->4 -> the fade continues and status becomes 4, not 3, at SWAP.
- During FADE_IN at level 6, status_req changes to a new value -> level goes to 4 on the next frame_tick (FADE_OUT); no jump to 16 or 0.
- With SCENE_COLOR_KEY_EN defined, is_door=1 with door_color=000000 and is_bg=1 with bg_color=123456 -> output 12,34,56. Without the macro -> 00,00,00.
